// File: rtl/btn_sw_reader.sv
// AXI-lite read-side user logic: synchronises and debounces buttons/switches,
// latches sticky press events, counts BTN0 presses and serves status reads.
module btn_sw_reader #(
  parameter int unsigned NUM_BTN         = 4,
  parameter int unsigned NUM_SW          = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic               S_AXI_ACLK,
  input  logic               S_AXI_ARESET,
  input  logic               slv_reg_rden,
  input  logic [2:0]         axi_araddr,
  input  logic [NUM_BTN-1:0] BTN,
  input  logic [NUM_SW-1:0]  SW,
  output logic [31:0]        S_AXI_RDATA,
  output logic               rdata_valid
);

  localparam int unsigned NumIn = NUM_BTN + NUM_SW;
  localparam int unsigned CntW  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [NumIn-1:0]   w_raw;
  logic [NumIn-1:0]   r_sync1;
  logic [NumIn-1:0]   r_sync2;
  logic [NumIn-1:0]   r_deb;
  logic [NumIn-1:0]   w_deb_d;
  logic [CntW-1:0]    r_cnt   [NumIn];
  logic [CntW-1:0]    w_cnt_d [NumIn];
  logic [NUM_BTN-1:0] w_btn_rise;
  logic [NUM_BTN-1:0] r_event;
  logic [7:0]         r_press_cnt;
  logic               w_clr;
  logic [31:0]        w_rd_word;
  logic [31:0]        r_rdata;
  logic               r_valid;

  assign w_raw = {SW, BTN};

  // Per-bit debounce: d follows s only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
  always_comb begin
    for (int i = 0; i < NumIn; i++) begin
      w_deb_d[i] = r_deb[i];
      w_cnt_d[i] = r_cnt[i];
      if (r_sync2[i] == r_deb[i]) begin
        w_cnt_d[i] = '0;
      end else if (r_cnt[i] == CntMax) begin
        w_deb_d[i] = r_sync2[i];
        w_cnt_d[i] = '0;
      end else begin
        w_cnt_d[i] = r_cnt[i] + CntW'(1);
      end
    end
  end

  assign w_btn_rise = w_deb_d[NUM_BTN-1:0] & ~r_deb[NUM_BTN-1:0];
  assign w_clr      = slv_reg_rden && (axi_araddr == 3'd1);

  always_comb begin
    w_rd_word = '0;
    case (axi_araddr)
      3'd0: begin
        w_rd_word[NUM_BTN-1:0]  = r_deb[NUM_BTN-1:0];
        w_rd_word[NUM_SW+7:8]   = r_deb[NumIn-1:NUM_BTN];
      end
      3'd1:    w_rd_word[NUM_BTN-1:0] = r_event;
      3'd2:    w_rd_word[7:0]         = r_press_cnt;
      3'd3:    w_rd_word              = 32'h5EC0_0001;
      default: w_rd_word              = '0;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      for (int i = 0; i < NumIn; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_deb   <= w_deb_d;
      for (int i = 0; i < NumIn; i++) r_cnt[i] <= w_cnt_d[i];
    end
  end

  // Set wins over clear so a press landing on the clearing read is kept for the next one.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_event     <= '0;
      r_press_cnt <= '0;
      r_rdata     <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_event <= (r_event & ~{NUM_BTN{w_clr}}) | w_btn_rise;
      if (w_btn_rise[0]) r_press_cnt <= r_press_cnt + 8'd1;
      if (slv_reg_rden) r_rdata <= w_rd_word;
      r_valid <= slv_reg_rden;
    end
  end

  assign S_AXI_RDATA = r_rdata;
  assign rdata_valid = r_valid;

endmodule

// File: tb/tb_btn_sw_reader.sv
// Directed self-checking bench for btn_sw_reader with DEBOUNCE_CYCLES=4.
module tb_btn_sw_reader;

  localparam int unsigned NB = 4;
  localparam int unsigned NS = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rden = 1'b0;
  logic [2:0]    addr = 3'd0;
  logic [NB-1:0] btn = '0;
  logic [NS-1:0] sw = '0;
  logic [31:0]   rdata;
  logic          valid;

  int total = 0;
  int bad   = 0;

  btn_sw_reader #(
    .NUM_BTN        (NB),
    .NUM_SW         (NS),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .S_AXI_ACLK  (clk),
    .S_AXI_ARESET(rst),
    .slv_reg_rden(rden),
    .axi_araddr  (addr),
    .BTN         (btn),
    .SW          (sw),
    .S_AXI_RDATA (rdata),
    .rdata_valid (valid)
  );

  always #5 clk = ~clk;

  // All tasks start and end 1 time unit after a rising edge.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [2:0] a, output logic [31:0] d, output logic v);
    rden = 1'b1;
    addr = a;
    cycles(1);
    rden = 1'b0;
    d = rdata;
    v = valid;
  endtask

  task automatic press(input int idx, input int hold);
    btn[idx] = 1'b1;
    cycles(hold);
    btn[idx] = 1'b0;
    cycles(8);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic        v;
    cycles(3);
    rst = 1'b0;
    cycles(2);
    press(0, 5);
    do_read(3'd3, d, v);
    total++;
    if (d !== 32'h5EC0_0001 || v !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_id: got %h/%b want 5ec00001/1", d, v);
    end
    #3 rst = 1'b1;
    #1;
    total++;
    if (rdata !== 32'h0 || valid !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got %h/%b want 0/0", rdata, valid);
    end
    cycles(1);
    rst = 1'b0;
    cycles(1);
    for (int a = 0; a < 3; a++) begin
      do_read(3'(a), d, v);
      total++;
      if (d !== 32'h0) begin
        bad++;
        $display("FAIL reset_addr%0d: got %h want 0", a, d);
      end
    end
    do_read(3'd3, d, v);
    total++;
    if (d !== 32'h5EC0_0001 || v !== 1'b1) begin
      bad++;
      $display("FAIL reset_id: got %h/%b want 5ec00001/1", d, v);
    end
    cycles(1);
    total++;
    if (valid !== 1'b0) begin
      bad++;
      $display("FAIL valid_width: got %b want 0", valid);
    end
  endtask

  task automatic test_debounce;
    logic [31:0] d;
    logic        v;
    btn[1] = 1'b1;
    cycles(3);
    btn[1] = 1'b0;
    cycles(10);
    do_read(3'd0, d, v);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("FAIL glitch_level: got %h want 0", d);
    end
    do_read(3'd1, d, v);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("FAIL glitch_event: got %h want 0", d);
    end
    // Pin rises now; debounced level updates on the 6th edge after.
    btn[1] = 1'b1;
    cycles(5);
    rden = 1'b1;
    addr = 3'd0;
    cycles(1);
    total++;
    if (rdata[1] !== 1'b0) begin
      bad++;
      $display("FAIL deb_edge5: got %b want 0", rdata[1]);
    end
    cycles(1);
    rden = 1'b0;
    total++;
    if (rdata[1] !== 1'b1) begin
      bad++;
      $display("FAIL deb_edge6: got %b want 1", rdata[1]);
    end
    cycles(3);
  endtask

  task automatic test_clear_on_read;
    logic [31:0] d;
    logic        v;
    do_read(3'd1, d, v);
    total++;
    if (d !== 32'h2) begin
      bad++;
      $display("FAIL event_first: got %h want 2", d);
    end
    do_read(3'd1, d, v);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("FAIL event_cleared: got %h want 0", d);
    end
    do_read(3'd0, d, v);
    total++;
    if (d !== 32'h2) begin
      bad++;
      $display("FAIL level_held: got %h want 2", d);
    end
    btn[1] = 1'b0;
    cycles(10);
  endtask

  task automatic test_set_clear;
    logic [31:0] d;
    logic        v;
    btn[2] = 1'b1;
    cycles(5);
    do_read(3'd1, d, v);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("FAIL setclr_same: got %h want 0", d);
    end
    do_read(3'd1, d, v);
    total++;
    if (d !== 32'h4) begin
      bad++;
      $display("FAIL setclr_next: got %h want 4", d);
    end
    btn[2] = 1'b0;
    cycles(10);
  endtask

  task automatic test_counter_wrap;
    logic [31:0] d;
    logic        v;
    for (int i = 0; i < 256; i++) begin
      press(0, 5);
      if (i == 99) begin
        do_read(3'd2, d, v);
        total++;
        if (d !== 32'h64) begin
          bad++;
          $display("FAIL cnt_100: got %h want 64", d);
        end
        do_read(3'd1, d, v);
      end
    end
    do_read(3'd2, d, v);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("FAIL cnt_wrap: got %h want 0", d);
    end
    press(0, 5);
    do_read(3'd2, d, v);
    total++;
    if (d !== 32'h1) begin
      bad++;
      $display("FAIL cnt_after_wrap: got %h want 1", d);
    end
  endtask

  task automatic test_switches;
    logic [31:0] d;
    logic        v;
    do_read(3'd1, d, v);
    total++;
    if (d !== 32'h1) begin
      bad++;
      $display("FAIL event_btn0: got %h want 1", d);
    end
    sw = 2'b10;
    cycles(8);
    do_read(3'd0, d, v);
    total++;
    if (d !== 32'h200) begin
      bad++;
      $display("FAIL sw_level: got %h want 200", d);
    end
    do_read(3'd1, d, v);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("FAIL sw_no_event: got %h want 0", d);
    end
    do_read(3'd5, d, v);
    total++;
    if (d !== 32'h0 || v !== 1'b1) begin
      bad++;
      $display("FAIL addr5: got %h/%b want 0/1", d, v);
    end
  endtask

  task automatic test_back_to_back;
    rden = 1'b1;
    addr = 3'd0;
    cycles(1);
    addr = 3'd3;
    total++;
    if (rdata !== 32'h200 || valid !== 1'b1) begin
      bad++;
      $display("FAIL b2b_first: got %h/%b want 200/1", rdata, valid);
    end
    cycles(1);
    rden = 1'b0;
    total++;
    if (rdata !== 32'h5EC0_0001 || valid !== 1'b1) begin
      bad++;
      $display("FAIL b2b_second: got %h/%b want 5ec00001/1", rdata, valid);
    end
    cycles(1);
    total++;
    if (rdata !== 32'h5EC0_0001 || valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_hold: got %h/%b want 5ec00001/0", rdata, valid);
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_clear_on_read();
    test_set_clear();
    test_counter_wrap();
    test_switches();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
